alu_issue_stage: RTL and testbench

Decode/issue pipeline stage that drives the ALU's operand and control interface. It accepts one instruction per cycle with its two register-file read values, decodes RV32I OP and OP-IMM instructions into the 4-bit ALU control code, and selects the second operand: `rs2` or the immediate. It holds the result in a one-entry registered stage with a valid/ready handshake, flush and an issue counter. It sits between register-file read and the ALU.

---
 rtl/alu_issue_stage.sv | 182 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I OP / OP-IMM instructions into ALU control and
// operands, and holds the result in a one-entry valid/ready stage with flush
// and a count of completed output handshakes.
module alu_issue_stage #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  inst,
    input  logic [n-1:0] rs1_data,
    input  logic [n-1:0] rs2_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] op_a,
    output logic [n-1:0] op_b,
    output logic [3:0]   alu_ctrl,
    output logic [4:0]   rd,
    output logic         reg_write,
    output logic         illegal,
    output logic [31:0]  issue_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SLL  = 4'b0011;
    localparam logic [3:0] CTRL_SLT  = 4'b0100;
    localparam logic [3:0] CTRL_SLTU = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_XOR  = 4'b0111;
    localparam logic [3:0] CTRL_SRL  = 4'b1000;
    localparam logic [3:0] CTRL_SRA  = 4'b1010;

    // Held entry
    logic         r_out_valid;
    logic [n-1:0] r_op_a;
    logic [n-1:0] r_op_b;
    logic [3:0]   r_alu_ctrl;
    logic [4:0]   r_rd;
    logic         r_reg_write;
    logic         r_illegal;
    logic [31:0]  r_issue_cnt;

    // Decode results
    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    logic [n-1:0] w_imm_sext;
    logic [n-1:0] w_shamt_zext;
    logic [3:0]   w_ctrl;
    logic [n-1:0] w_op_b;
    logic         w_legal;
    logic         w_accept;
    logic         w_consume;
    logic         w_unused_rs1_field;

    assign w_opcode     = inst[6:0];
    assign w_funct3     = inst[14:12];
    assign w_funct7     = inst[31:25];
    assign w_imm_sext   = {{(n-12){inst[31]}}, inst[31:20]};
    assign w_shamt_zext = {{(n-5){1'b0}}, inst[24:20]};

    // The rs1 field is resolved upstream; its value arrives on rs1_data.
    assign w_unused_rs1_field = ^inst[19:15];

    // Decode opcode/funct fields into ALU control, second operand and legality.
    always_comb begin
        w_ctrl  = CTRL_ADD;
        w_op_b  = '0;
        w_legal = 1'b0;
        if (w_opcode == OPC_OP) begin
            w_op_b  = rs2_data;
            w_legal = (w_funct7 == F7_ZERO);
            case (w_funct3)
                3'b000: begin
                    w_ctrl  = (w_funct7 == F7_ALT) ? CTRL_SUB : CTRL_ADD;
                    w_legal = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
                end
                3'b001: w_ctrl = CTRL_SLL;
                3'b010: w_ctrl = CTRL_SLT;
                3'b011: w_ctrl = CTRL_SLTU;
                3'b100: w_ctrl = CTRL_XOR;
                3'b101: begin
                    w_ctrl  = (w_funct7 == F7_ALT) ? CTRL_SRA : CTRL_SRL;
                    w_legal = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
                end
                3'b110: w_ctrl = CTRL_OR;
                default: w_ctrl = CTRL_AND;
            endcase
        end else if (w_opcode == OPC_OP_IMM) begin
            w_op_b  = w_imm_sext;
            w_legal = 1'b1;
            case (w_funct3)
                3'b000: w_ctrl = CTRL_ADD;
                3'b001: begin
                    // Shift-immediates carry a 5-bit shamt, not a signed immediate.
                    w_op_b  = w_shamt_zext;
                    w_ctrl  = CTRL_SLL;
                    w_legal = (w_funct7 == F7_ZERO);
                end
                3'b010: w_ctrl = CTRL_SLT;
                3'b011: w_ctrl = CTRL_SLTU;
                3'b100: w_ctrl = CTRL_XOR;
                3'b101: begin
                    w_op_b  = w_shamt_zext;
                    w_ctrl  = (w_funct7 == F7_ALT) ? CTRL_SRA : CTRL_SRL;
                    w_legal = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
                end
                3'b110: w_ctrl = CTRL_OR;
                default: w_ctrl = CTRL_AND;
            endcase
        end
        // Illegal entries still issue, as a harmless rs1 + 0 with no writeback.
        if (!w_legal) begin
            w_ctrl = CTRL_ADD;
            w_op_b = '0;
        end
    end

    assign in_ready  = (!r_out_valid || out_ready) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_out_valid && out_ready;

    // Track entry occupancy; flush wins over any accept in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    // Load the decoded entry on accept; hold it otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_alu_ctrl  <= 4'b0000;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_op_a      <= rs1_data;
            r_op_b      <= w_op_b;
            r_alu_ctrl  <= w_ctrl;
            r_rd        <= inst[11:7];
            r_reg_write <= w_legal && (inst[11:7] != 5'd0);
            r_illegal   <= !w_legal;
        end
    end

    // Count every output handshake, including one that coincides with flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= 32'd0;
        end else if (w_consume) begin
            r_issue_cnt <= r_issue_cnt + 32'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign alu_ctrl  = r_alu_ctrl;
    assign rd        = r_rd;
    assign reg_write = r_reg_write;
    assign illegal   = r_illegal;
    assign issue_cnt = r_issue_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: decode vector table plus handshake,
// back-pressure, flush, asynchronous reset and counter wrap sequences.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
    logic [31:0] issue_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [31:0] opb;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    alu_issue_stage #(.n(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_ctrl  (alu_ctrl),
        .rd        (rd),
        .reg_write (reg_write),
        .illegal   (illegal),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy, input logic fl);
        in_valid  = v;
        inst      = ins;
        rs1_data  = a;
        rs2_data  = b;
        out_ready = ordy;
        flush     = fl;
    endtask

    int exp_cnt;

    initial begin
        //                 inst          rs1           rs2           ctrl     opb           rd  rw  ill
        vecs[0]  = '{32'h002081B3, 32'd5,        32'd7,        4'b0010, 32'd7,        5'd3, 1'b1, 1'b0}; // ADD
        vecs[1]  = '{32'h402081B3, 32'd5,        32'd7,        4'b0110, 32'd7,        5'd3, 1'b1, 1'b0}; // SUB
        vecs[2]  = '{32'hFFF00093, 32'd0,        32'd9,        4'b0010, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0}; // ADDI -1
        vecs[3]  = '{32'h4032D293, 32'h80000000, 32'd9,        4'b1010, 32'd3,        5'd5, 1'b1, 1'b0}; // SRAI 3
        vecs[4]  = '{32'h00000000, 32'h12345678, 32'd9,        4'b0010, 32'd0,        5'd0, 1'b0, 1'b1}; // all zero
        vecs[5]  = '{32'h202081B3, 32'hCAFEF00D, 32'd9,        4'b0010, 32'd0,        5'd3, 1'b0, 1'b1}; // bad funct7
        vecs[6]  = '{32'h00208033, 32'd11,       32'd22,       4'b0010, 32'd22,       5'd0, 1'b0, 1'b0}; // ADD x0
        vecs[7]  = '{32'h0050B213, 32'd1,        32'd2,        4'b0101, 32'd5,        5'd4, 1'b1, 1'b0}; // SLTIU 5
        vecs[8]  = '{32'h00209333, 32'd3,        32'hA5A5A5A5, 4'b0011, 32'hA5A5A5A5, 5'd6, 1'b1, 1'b0}; // SLL
        vecs[9]  = '{32'hFF00F393, 32'd4,        32'd2,        4'b0000, 32'hFFFFFFF0, 5'd7, 1'b1, 1'b0}; // ANDI -16
        vecs[10] = '{32'h0200D293, 32'd6,        32'd2,        4'b0010, 32'd0,        5'd5, 1'b0, 1'b1}; // SRLI bad funct7

        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_b", op_b, 32'd0);
        chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("rst_rd_rw_ill", {25'd0, rd, reg_write, illegal}, 32'd0);
        chk("rst_issue_cnt", issue_cnt, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // Back-to-back decode table with the consumer always ready
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].inst, vecs[i].rs1, vecs[i].rs2, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_ctrl", i), {28'd0, alu_ctrl}, {28'd0, vecs[i].ctrl});
            chk($sformatf("v%0d_op_a", i), op_a, vecs[i].rs1);
            chk($sformatf("v%0d_op_b", i), op_b, vecs[i].opb);
            chk($sformatf("v%0d_rd", i), {27'd0, rd}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d_reg_write", i), {31'd0, reg_write}, {31'd0, vecs[i].rw});
            chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
            chk($sformatf("v%0d_cnt", i), issue_cnt, i);
        end
        exp_cnt = NV - 1;

        // Drain the last entry
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        exp_cnt++;
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_cnt", issue_cnt, exp_cnt);

        // Back-pressure: fill with ADD, then stall three cycles
        @(negedge clk);
        drive(1'b1, vecs[0].inst, 32'd5, 32'd7, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("bp_fill_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, vecs[1].inst, 32'd99, 32'd98, 1'b0, 1'b0);
            #1;
            chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_ctrl", k), {28'd0, alu_ctrl}, 32'd2);
            chk($sformatf("bp%0d_op_a", k), op_a, 32'd5);
            chk($sformatf("bp%0d_op_b", k), op_b, 32'd7);
            chk($sformatf("bp%0d_cnt", k), issue_cnt, exp_cnt);
        end

        // Stream four instructions at full throughput
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (k == 3) ? 7 : k + 1;
            @(negedge clk);
            drive(1'b1, vecs[idx].inst, vecs[idx].rs1, vecs[idx].rs2, 1'b1, 1'b0);
            #1;
            chk($sformatf("st%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            exp_cnt++;
            chk($sformatf("st%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("st%0d_ctrl", k), {28'd0, alu_ctrl}, {28'd0, vecs[idx].ctrl});
            chk($sformatf("st%0d_op_b", k), op_b, vecs[idx].opb);
            chk($sformatf("st%0d_cnt", k), issue_cnt, exp_cnt);
        end
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        exp_cnt++;
        chk("st_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("st_drain_cnt", issue_cnt, exp_cnt);

        // Flush while holding a stalled entry, then re-present
        @(negedge clk);
        drive(1'b1, vecs[0].inst, 32'd5, 32'd7, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("fl_fill_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        drive(1'b1, vecs[1].inst, 32'd8, 32'd4, 1'b0, 1'b1);
        #1;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("fl_valid_cleared", {31'd0, out_valid}, 32'd0);
        chk("fl_cnt", issue_cnt, exp_cnt);
        @(negedge clk);
        drive(1'b1, vecs[1].inst, 32'd8, 32'd4, 1'b0, 1'b0);
        #1;
        chk("fl_reissue_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("fl_reissue_valid", {31'd0, out_valid}, 32'd1);
        chk("fl_reissue_ctrl", {28'd0, alu_ctrl}, 32'd6);
        chk("fl_reissue_op_a", op_a, 32'd8);

        // Flush coinciding with a handshake still counts it
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        exp_cnt++;
        chk("flc_valid", {31'd0, out_valid}, 32'd0);
        chk("flc_cnt", issue_cnt, exp_cnt);

        // Asynchronous reset while an entry is held
        @(negedge clk);
        drive(1'b1, vecs[3].inst, 32'h80000000, 32'd9, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("ar_fill_valid", {31'd0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_op_a", op_a, 32'd0);
        chk("ar_op_b", op_b, 32'd0);
        chk("ar_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("ar_rd_rw_ill", {25'd0, rd, reg_write, illegal}, 32'd0);
        chk("ar_issue_cnt", issue_cnt, 32'd0);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Counter wrap from all-ones on one handshake
        @(negedge clk);
        drive(1'b1, vecs[0].inst, 32'd5, 32'd7, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("wr_fill_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        force dut.r_issue_cnt = 32'hFFFFFFFF;
        #1;
        release dut.r_issue_cnt;
        #1;
        chk("wr_preload", issue_cnt, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        chk("wr_cnt_wrapped", issue_cnt, 32'd0);
        chk("wr_valid", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
